// File: rtl/user_score_tracker_pkg.sv
// Shared grade codes, FSM state encoding and rank-to-display-code mapping
// for the piano grading engine.
package user_score_tracker_pkg;

    localparam logic [5:0] GRADE_S    = 6'b010010;
    localparam logic [5:0] GRADE_A    = 6'b000000;
    localparam logic [5:0] GRADE_B    = 6'b000001;
    localparam logic [5:0] GRADE_C    = 6'b000010;
    localparam logic [5:0] GRADE_D    = 6'b000011;
    localparam logic [5:0] GRADE_NONE = 6'b111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PLAY   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Rank 0..4 is S..D; anything else is shown as blank.
    function automatic logic [5:0] rank_to_code(input logic [2:0] rank);
        case (rank)
            3'd0:    return GRADE_S;
            3'd1:    return GRADE_A;
            3'd2:    return GRADE_B;
            3'd3:    return GRADE_C;
            3'd4:    return GRADE_D;
            default: return GRADE_NONE;
        endcase
    endfunction

endpackage

// File: rtl/user_score_tracker_mismatch_timer.sv
// Counts consecutive mismatch cycles; every ERR_TICKS of them adds one
// saturating error. Any matching cycle restarts the run.
module user_score_tracker_mismatch_timer #(
    parameter int ERR_TICKS = 100000,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             mismatch,
    output logic [ERR_W-1:0] err_count
);

    localparam int TICK_W = (ERR_TICKS > 1) ? $clog2(ERR_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ERR_TICKS - 1);

    logic [TICK_W-1:0] tick_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt  <= '0;
            err_count <= '0;
        end else if (clear) begin
            tick_cnt  <= '0;
            err_count <= '0;
        end else if (enable) begin
            if (!mismatch) begin
                tick_cnt <= '0;
            end else if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (err_count != '1)
                    err_count <= err_count + ERR_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/user_score_tracker.sv
// Multi-user grading engine: times note mismatches during a song, grades
// the error count and keeps last/best grade per user slot.
module user_score_tracker
    import user_score_tracker_pkg::*;
#(
    parameter int NUM_USERS = 4,
    parameter int NOTE_W    = 10,
    parameter int ERR_TICKS = 100000,
    parameter int ERR_W     = 8,
    parameter int TH_A      = 1,
    parameter int TH_B      = 3,
    parameter int TH_C      = 6,
    parameter int TH_D      = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(NUM_USERS)-1:0] user_sel,
    input  logic                         play_start,
    input  logic                         song_done,
    input  logic [NOTE_W-1:0]            note_expected,
    input  logic [NOTE_W-1:0]            note_played,
    output logic [$clog2(NUM_USERS)-1:0] active_user,
    output logic                         busy,
    output logic [ERR_W-1:0]             err_count,
    output logic [5:0]                   live_grade,
    output logic [5:0]                   last_grade,
    output logic [5:0]                   best_grade,
    output logic                         grade_valid
);

    state_t                 state;
    logic [2:0]             last_rank [NUM_USERS];
    logic [2:0]             best_rank [NUM_USERS];
    logic [NUM_USERS-1:0]   slot_vld;
    logic [2:0]             rank;
    logic                   timer_clear;
    logic                   timer_en;

    // play_start restarts the song from IDLE or mid-song alike.
    assign timer_clear = play_start && (state == ST_IDLE || state == ST_PLAY);
    assign timer_en    = (state == ST_PLAY);

    user_score_tracker_mismatch_timer #(
        .ERR_TICKS (ERR_TICKS),
        .ERR_W     (ERR_W)
    ) u_mismatch_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .enable    (timer_en),
        .mismatch  (note_played != note_expected),
        .err_count (err_count)
    );

    always_comb begin
        if (32'(err_count) < TH_A)
            rank = 3'd0;
        else if (32'(err_count) < TH_B)
            rank = 3'd1;
        else if (32'(err_count) < TH_C)
            rank = 3'd2;
        else if (32'(err_count) < TH_D)
            rank = 3'd3;
        else
            rank = 3'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            active_user <= '0;
            grade_valid <= 1'b0;
            slot_vld    <= '0;
            for (int i = 0; i < NUM_USERS; i++) begin
                last_rank[i] <= '0;
                best_rank[i] <= '0;
            end
        end else begin
            grade_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (32'(user_sel) < NUM_USERS)
                        active_user <= user_sel;
                    if (play_start)
                        state <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (!play_start && song_done)
                        state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    last_rank[active_user] <= rank;
                    if (!slot_vld[active_user] || rank < best_rank[active_user])
                        best_rank[active_user] <= rank;
                    slot_vld[active_user] <= 1'b1;
                    grade_valid           <= 1'b1;
                    state                 <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state == ST_PLAY) || (state == ST_COMMIT);
    assign live_grade = rank_to_code(rank);

    always_comb begin
        last_grade = GRADE_NONE;
        best_grade = GRADE_NONE;
        if (slot_vld[active_user]) begin
            last_grade = rank_to_code(last_rank[active_user]);
            best_grade = rank_to_code(best_rank[active_user]);
        end
    end

endmodule

// File: tb/tb_user_score_tracker.sv
// Directed bench for user_score_tracker with ERR_TICKS=4; a second
// instance with NUM_USERS=3 covers out-of-range user selection.
module tb_user_score_tracker;

    localparam logic [5:0] G_S    = 6'b010010;
    localparam logic [5:0] G_A    = 6'b000000;
    localparam logic [5:0] G_B    = 6'b000001;
    localparam logic [5:0] G_D    = 6'b000011;
    localparam logic [5:0] G_NONE = 6'b111111;
    localparam logic [9:0] NOTE_E = 10'h005;
    localparam logic [9:0] NOTE_X = 10'h006;

    logic       clk;
    logic       rst;
    logic [1:0] user_sel;
    logic       play_start;
    logic       song_done;
    logic [9:0] note_expected;
    logic [9:0] note_played;
    logic [1:0] active_user;
    logic       busy;
    logic [7:0] err_count;
    logic [5:0] live_grade;
    logic [5:0] last_grade;
    logic [5:0] best_grade;
    logic       grade_valid;

    logic [1:0] user_sel3;
    logic [1:0] active_user3;
    logic       busy3;
    logic [7:0] err_count3;
    logic [5:0] live_grade3;
    logic [5:0] last_grade3;
    logic [5:0] best_grade3;
    logic       grade_valid3;

    int total;
    int bad;

    user_score_tracker #(.NUM_USERS(4), .NOTE_W(10), .ERR_TICKS(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .user_sel(user_sel), .play_start(play_start),
        .song_done(song_done), .note_expected(note_expected), .note_played(note_played),
        .active_user(active_user), .busy(busy), .err_count(err_count),
        .live_grade(live_grade), .last_grade(last_grade), .best_grade(best_grade),
        .grade_valid(grade_valid)
    );

    user_score_tracker #(.NUM_USERS(3), .NOTE_W(10), .ERR_TICKS(4), .ERR_W(8)) dut3 (
        .clk(clk), .rst(rst), .user_sel(user_sel3), .play_start(1'b0),
        .song_done(1'b0), .note_expected(NOTE_E), .note_played(NOTE_E),
        .active_user(active_user3), .busy(busy3), .err_count(err_count3),
        .live_grade(live_grade3), .last_grade(last_grade3), .best_grade(best_grade3),
        .grade_valid(grade_valid3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_song;
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
    endtask

    task automatic mismatch(input int n);
        note_played = NOTE_X;
        repeat (n) tick();
        note_played = NOTE_E;
    endtask

    task automatic end_song;
        note_played = NOTE_E;
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        total++; if (active_user !== 2'd0) begin bad++; $display("FAIL reset_active_user got %0d want 0", active_user); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL reset_err_count got %0d want 0", err_count); end
        total++; if (live_grade !== G_S) begin bad++; $display("FAIL reset_live_grade got %b want %b", live_grade, G_S); end
        total++; if (last_grade !== G_NONE) begin bad++; $display("FAIL reset_last_grade got %b want %b", last_grade, G_NONE); end
        total++; if (best_grade !== G_NONE) begin bad++; $display("FAIL reset_best_grade got %b want %b", best_grade, G_NONE); end
        total++; if (grade_valid !== 1'b0) begin bad++; $display("FAIL reset_grade_valid got %b want 0", grade_valid); end
    endtask

    task automatic test_user_select;
        user_sel = 2'd2;
        tick();
        total++; if (active_user !== 2'd2) begin bad++; $display("FAIL sel_active_user got %0d want 2", active_user); end
        total++; if (last_grade !== G_NONE) begin bad++; $display("FAIL sel_last_grade got %b want %b", last_grade, G_NONE); end
        total++; if (best_grade !== G_NONE) begin bad++; $display("FAIL sel_best_grade got %b want %b", best_grade, G_NONE); end
        total++; if (live_grade !== G_S) begin bad++; $display("FAIL sel_live_grade got %b want %b", live_grade, G_S); end
    endtask

    task automatic test_user_range_n3;
        user_sel3 = 2'd2;
        tick();
        total++; if (active_user3 !== 2'd2) begin bad++; $display("FAIL n3_sel2 got %0d want 2", active_user3); end
        user_sel3 = 2'd3;
        tick();
        tick();
        total++; if (active_user3 !== 2'd2) begin bad++; $display("FAIL n3_sel3_ignored got %0d want 2", active_user3); end
    endtask

    task automatic test_grade_s;
        start_song();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL s_busy_play got %b want 1", busy); end
        mismatch(0);
        repeat (5) tick();
        end_song();
        total++; if (grade_valid !== 1'b0) begin bad++; $display("FAIL s_gv_commit got %b want 0", grade_valid); end
        tick();
        total++; if (grade_valid !== 1'b1) begin bad++; $display("FAIL s_gv_pulse got %b want 1", grade_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL s_busy_idle got %b want 0", busy); end
        total++; if (last_grade !== G_S) begin bad++; $display("FAIL s_last got %b want %b", last_grade, G_S); end
        total++; if (best_grade !== G_S) begin bad++; $display("FAIL s_best got %b want %b", best_grade, G_S); end
        tick();
        total++; if (grade_valid !== 1'b0) begin bad++; $display("FAIL s_gv_one_cycle got %b want 0", grade_valid); end
    endtask

    task automatic test_grades;
        user_sel = 2'd1;
        tick();
        // 12 mismatch cycles -> 3 errors -> B
        start_song();
        mismatch(12);
        total++; if (err_count !== 8'd3) begin bad++; $display("FAIL b_err got %0d want 3", err_count); end
        total++; if (live_grade !== G_B) begin bad++; $display("FAIL b_live got %b want %b", live_grade, G_B); end
        end_song();
        tick();
        total++; if (last_grade !== G_B) begin bad++; $display("FAIL b_last got %b want %b", last_grade, G_B); end
        total++; if (best_grade !== G_B) begin bad++; $display("FAIL b_best got %b want %b", best_grade, G_B); end
        // 4 mismatch cycles -> 1 error -> A, improves best
        start_song();
        mismatch(4);
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL a_err got %0d want 1", err_count); end
        end_song();
        tick();
        total++; if (last_grade !== G_A) begin bad++; $display("FAIL a_last got %b want %b", last_grade, G_A); end
        total++; if (best_grade !== G_A) begin bad++; $display("FAIL a_best got %b want %b", best_grade, G_A); end
        // 40 mismatch cycles -> 10 errors -> D, best stays A
        start_song();
        mismatch(40);
        total++; if (err_count !== 8'd10) begin bad++; $display("FAIL d_err got %0d want 10", err_count); end
        total++; if (live_grade !== G_D) begin bad++; $display("FAIL d_live got %b want %b", live_grade, G_D); end
        end_song();
        tick();
        total++; if (last_grade !== G_D) begin bad++; $display("FAIL d_last got %b want %b", last_grade, G_D); end
        total++; if (best_grade !== G_A) begin bad++; $display("FAIL d_best got %b want %b", best_grade, G_A); end
    endtask

    task automatic test_tick_clear;
        start_song();
        mismatch(3);
        tick();
        mismatch(3);
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL tclr_err got %0d want 0", err_count); end
        end_song();
        tick();
        total++; if (last_grade !== G_S) begin bad++; $display("FAIL tclr_last got %b want %b", last_grade, G_S); end
        total++; if (best_grade !== G_S) begin bad++; $display("FAIL tclr_best got %b want %b", best_grade, G_S); end
    endtask

    task automatic test_done_same_edge;
        start_song();
        mismatch(3);
        note_played = NOTE_X;
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        note_played = NOTE_E;
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL edge_err got %0d want 1", err_count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL edge_busy_commit got %b want 1", busy); end
        tick();
        total++; if (grade_valid !== 1'b1) begin bad++; $display("FAIL edge_gv got %b want 1", grade_valid); end
        total++; if (last_grade !== G_A) begin bad++; $display("FAIL edge_last got %b want %b", last_grade, G_A); end
        total++; if (best_grade !== G_S) begin bad++; $display("FAIL edge_best got %b want %b", best_grade, G_S); end
    endtask

    task automatic test_user_lock;
        start_song();
        user_sel = 2'd3;
        mismatch(2);
        total++; if (active_user !== 2'd1) begin bad++; $display("FAIL lock_play got %0d want 1", active_user); end
        end_song();
        total++; if (active_user !== 2'd1) begin bad++; $display("FAIL lock_commit got %0d want 1", active_user); end
        tick();
        total++; if (active_user !== 2'd1) begin bad++; $display("FAIL lock_idle_first got %0d want 1", active_user); end
        total++; if (last_grade !== G_S) begin bad++; $display("FAIL lock_last_u1 got %b want %b", last_grade, G_S); end
        tick();
        total++; if (active_user !== 2'd3) begin bad++; $display("FAIL lock_switch got %0d want 3", active_user); end
        total++; if (last_grade !== G_NONE) begin bad++; $display("FAIL lock_last_u3 got %b want %b", last_grade, G_NONE); end
        total++; if (best_grade !== G_NONE) begin bad++; $display("FAIL lock_best_u3 got %b want %b", best_grade, G_NONE); end
        user_sel = 2'd2;
        tick();
        total++; if (last_grade !== G_S) begin bad++; $display("FAIL lock_last_u2 got %b want %b", last_grade, G_S); end
        total++; if (best_grade !== G_S) begin bad++; $display("FAIL lock_best_u2 got %b want %b", best_grade, G_S); end
    endtask

    task automatic test_restart;
        start_song();
        mismatch(8);
        total++; if (err_count !== 8'd2) begin bad++; $display("FAIL rs_err_before got %0d want 2", err_count); end
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rs_err_cleared got %0d want 0", err_count); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rs_busy got %b want 1", busy); end
        mismatch(4);
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL rs_err_after got %0d want 1", err_count); end
        end_song();
        tick();
        total++; if (last_grade !== G_A) begin bad++; $display("FAIL rs_last got %b want %b", last_grade, G_A); end
        total++; if (best_grade !== G_S) begin bad++; $display("FAIL rs_best got %b want %b", best_grade, G_S); end
    endtask

    task automatic test_done_idle;
        tick();
        song_done = 1'b1;
        tick();
        song_done = 1'b0;
        total++; if (grade_valid !== 1'b0) begin bad++; $display("FAIL idle_done_gv got %b want 0", grade_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_done_busy got %b want 0", busy); end
        tick();
        total++; if (grade_valid !== 1'b0) begin bad++; $display("FAIL idle_done_gv2 got %b want 0", grade_valid); end
    endtask

    task automatic test_reset_mid;
        start_song();
        mismatch(20);
        total++; if (err_count !== 8'd5) begin bad++; $display("FAIL rm_err_before got %0d want 5", err_count); end
        rst = 1'b1;
        #1;
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rm_err got %0d want 0", err_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got %b want 0", busy); end
        total++; if (active_user !== 2'd0) begin bad++; $display("FAIL rm_active got %0d want 0", active_user); end
        tick();
        total++; if (grade_valid !== 1'b0) begin bad++; $display("FAIL rm_gv got %b want 0", grade_valid); end
        rst = 1'b0;
        user_sel = 2'd1;
        tick();
        total++; if (grade_valid !== 1'b0) begin bad++; $display("FAIL rm_gv_after got %b want 0", grade_valid); end
        total++; if (active_user !== 2'd1) begin bad++; $display("FAIL rm_sel1 got %0d want 1", active_user); end
        total++; if (last_grade !== G_NONE) begin bad++; $display("FAIL rm_last_u1 got %b want %b", last_grade, G_NONE); end
        total++; if (best_grade !== G_NONE) begin bad++; $display("FAIL rm_best_u1 got %b want %b", best_grade, G_NONE); end
        user_sel = 2'd2;
        tick();
        total++; if (last_grade !== G_NONE) begin bad++; $display("FAIL rm_last_u2 got %b want %b", last_grade, G_NONE); end
        total++; if (best_grade !== G_NONE) begin bad++; $display("FAIL rm_best_u2 got %b want %b", best_grade, G_NONE); end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        user_sel      = 2'd0;
        user_sel3     = 2'd0;
        play_start    = 1'b0;
        song_done     = 1'b0;
        note_expected = NOTE_E;
        note_played   = NOTE_E;

        test_reset();
        test_user_select();
        test_user_range_n3();
        test_grade_s();
        test_grades();
        test_tick_clear();
        test_done_same_edge();
        test_user_lock();
        test_restart();
        test_done_idle();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
